// File: rtl/rx_pkt_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rx_pkt_buffer                                                |
// | Description : Store-and-forward RX packet buffer; drops bad/oversize frames |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module rx_pkt_buffer #(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic          apclk,
  input  logic          apreset,
  input  logic [63:0]   fromMac_axis_tdata,
  input  logic [7:0]    fromMac_axis_tkeep,
  input  logic [63:0]   fromMac_axis_tuser,
  input  logic          fromMac_axis_tlast,
  input  logic          fromMac_axis_tvalid,
  output logic          fromMac_axis_tready,
  output logic [63:0]   toHdr_axis_tdata,
  output logic [7:0]    toHdr_axis_tkeep,
  output logic [63:0]   toHdr_axis_tuser,
  output logic          toHdr_axis_tlast,
  output logic          toHdr_axis_tvalid,
  input  logic          toHdr_axis_tready,
  output logic [31:0]   drop_cnt,
  output logic [AW:0]   pkt_cnt
);

  localparam int          c_W     = 137;
  localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);
  localparam logic [1:0]  c_IDLE  = 2'd0;
  localparam logic [1:0]  c_WRITE = 2'd1;
  localparam logic [1:0]  c_DROP  = 2'd2;

  logic [c_W-1:0] r_mem [DEPTH];
  logic [1:0]     r_state, w_state_nxt;
  logic [AW:0]    r_wr_ptr, r_cm_ptr, r_rd_ptr;
  logic [AW:0]    w_used;
  logic           w_full, w_beat;
  logic           w_wr_en, w_commit, w_rewind, w_drop;
  logic           r_s1_valid;
  logic [c_W-1:0] r_s1_data;
  logic           w_out_load, w_rd_en, w_hs;

  assign fromMac_axis_tready = ~apreset;
  assign w_beat = fromMac_axis_tvalid & fromMac_axis_tready;
  assign w_used = r_wr_ptr - r_rd_ptr;
  assign w_full = (w_used == c_DEPTH);

  // Write FSM: state register
  always_ff @(posedge apclk) begin
    if (apreset) r_state <= c_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Write FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE, c_WRITE: begin
        if (w_beat) begin
          if (fromMac_axis_tlast) w_state_nxt = c_IDLE;
          else if (w_full)        w_state_nxt = c_DROP;
          else                    w_state_nxt = c_WRITE;
        end
      end
      c_DROP: begin
        if (w_beat && fromMac_axis_tlast) w_state_nxt = c_IDLE;
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Write FSM: datapath controls
  always_comb begin
    w_wr_en  = 1'b0;
    w_commit = 1'b0;
    w_rewind = 1'b0;
    w_drop   = 1'b0;
    if (w_beat) begin
      case (r_state)
        c_IDLE, c_WRITE: begin
          if (w_full) begin
            w_rewind = 1'b1;
            w_drop   = fromMac_axis_tlast;
          end else begin
            w_wr_en = 1'b1;
            if (fromMac_axis_tlast) begin
              if (fromMac_axis_tuser[0]) begin
                w_rewind = 1'b1;
                w_drop   = 1'b1;
              end else begin
                w_commit = 1'b1;
              end
            end
          end
        end
        c_DROP:  w_drop = fromMac_axis_tlast;
        default: ;
      endcase
    end
  end

  // A rewind takes priority over the increment from the same (bad) tlast write.
  always_ff @(posedge apclk) begin
    if (apreset) begin
      r_wr_ptr <= '0;
      r_cm_ptr <= '0;
    end else begin
      if (w_rewind)     r_wr_ptr <= r_cm_ptr;
      else if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_commit)     r_cm_ptr <= r_wr_ptr + 1'b1;
    end
  end

  always_ff @(posedge apclk) begin
    if (w_wr_en)
      r_mem[r_wr_ptr[AW-1:0]] <= {fromMac_axis_tdata, fromMac_axis_tkeep,
                                  fromMac_axis_tuser, fromMac_axis_tlast};
  end

  // Read side: RAM output register (s1) feeding the egress register.
  assign w_hs       = toHdr_axis_tvalid & toHdr_axis_tready;
  assign w_out_load = ~toHdr_axis_tvalid | toHdr_axis_tready;
  assign w_rd_en    = (r_rd_ptr != r_cm_ptr) & (~r_s1_valid | w_out_load);

  always_ff @(posedge apclk) begin
    if (w_rd_en) r_s1_data <= r_mem[r_rd_ptr[AW-1:0]];
  end

  always_ff @(posedge apclk) begin
    if (apreset) begin
      r_rd_ptr   <= '0;
      r_s1_valid <= 1'b0;
    end else begin
      if (w_rd_en)         r_rd_ptr   <= r_rd_ptr + 1'b1;
      if (w_rd_en)         r_s1_valid <= 1'b1;
      else if (w_out_load) r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge apclk) begin
    if (apreset) begin
      toHdr_axis_tvalid <= 1'b0;
      toHdr_axis_tdata  <= '0;
      toHdr_axis_tkeep  <= '0;
      toHdr_axis_tuser  <= '0;
      toHdr_axis_tlast  <= 1'b0;
    end else if (w_out_load) begin
      toHdr_axis_tvalid <= r_s1_valid;
      if (r_s1_valid)
        {toHdr_axis_tdata, toHdr_axis_tkeep, toHdr_axis_tuser, toHdr_axis_tlast} <= r_s1_data;
    end
  end

  // A commit and an egress tlast in the same cycle cancel out.
  always_ff @(posedge apclk) begin
    if (apreset) begin
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (w_commit && !(w_hs && toHdr_axis_tlast))      pkt_cnt <= pkt_cnt + 1'b1;
      else if (!w_commit && w_hs && toHdr_axis_tlast)   pkt_cnt <= pkt_cnt - 1'b1;
      if (w_drop) drop_cnt <= drop_cnt + 32'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rx_pkt_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_rx_pkt_buffer                                             |
// | Description : Directed self-checking bench for rx_pkt_buffer (DEPTH=16)    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_rx_pkt_buffer;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          apclk = 1'b0;
  logic          apreset;
  logic [63:0]   fromMac_axis_tdata;
  logic [7:0]    fromMac_axis_tkeep;
  logic [63:0]   fromMac_axis_tuser;
  logic          fromMac_axis_tlast;
  logic          fromMac_axis_tvalid;
  logic          fromMac_axis_tready;
  logic [63:0]   toHdr_axis_tdata;
  logic [7:0]    toHdr_axis_tkeep;
  logic [63:0]   toHdr_axis_tuser;
  logic          toHdr_axis_tlast;
  logic          toHdr_axis_tvalid;
  logic          toHdr_axis_tready;
  logic [31:0]   drop_cnt;
  logic [AW:0]   pkt_cnt;

  rx_pkt_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .apclk               (apclk),
    .apreset             (apreset),
    .fromMac_axis_tdata  (fromMac_axis_tdata),
    .fromMac_axis_tkeep  (fromMac_axis_tkeep),
    .fromMac_axis_tuser  (fromMac_axis_tuser),
    .fromMac_axis_tlast  (fromMac_axis_tlast),
    .fromMac_axis_tvalid (fromMac_axis_tvalid),
    .fromMac_axis_tready (fromMac_axis_tready),
    .toHdr_axis_tdata    (toHdr_axis_tdata),
    .toHdr_axis_tkeep    (toHdr_axis_tkeep),
    .toHdr_axis_tuser    (toHdr_axis_tuser),
    .toHdr_axis_tlast    (toHdr_axis_tlast),
    .toHdr_axis_tvalid   (toHdr_axis_tvalid),
    .toHdr_axis_tready   (toHdr_axis_tready),
    .drop_cnt            (drop_cnt),
    .pkt_cnt             (pkt_cnt)
  );

  always #5 apclk = ~apclk;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic [63:0] u;
    logic        l;
  } beat_t;

  typedef struct {
    int len;
    bit bad;
    bit deliver;
    int exp_drop;
  } vec_t;

  beat_t exp_q[$];
  int    n_checks    = 0;
  int    n_pass      = 0;
  int    egress_beats = 0;
  bit    sb_en       = 1'b0;
  bit    prev_stall  = 1'b0;
  bit    stream_done = 1'b0;
  beat_t prev_out;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_beat(input string name, input beat_t act, input beat_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got d=%h k=%h u=%h l=%b expected d=%h k=%h u=%h l=%b",
                  name, act.d, act.k, act.u, act.l, exp.d, exp.k, exp.u, exp.l);
  endtask

  // Non-last beats carry idx[0] in tuser[0] so only the tlast beat may mark a bad frame.
  function automatic beat_t mk_beat(input int pkt, input int idx, input int len, input bit bad);
    beat_t b;
    b.l = (idx == len - 1);
    b.d = {16'hA5C3, pkt[15:0], idx[15:0], 16'(pkt * 7 + idx)};
    b.k = b.l ? 8'h0F : 8'hFF;
    b.u = {pkt[15:0], idx[15:0], 31'h1234_5678, (b.l ? bad : idx[0])};
    return b;
  endfunction

  // Egress monitor: scoreboard compare and stall-hold check.
  always @(negedge apclk) begin
    beat_t cur;
    cur = {toHdr_axis_tdata, toHdr_axis_tkeep, toHdr_axis_tuser, toHdr_axis_tlast};
    if (!apreset && prev_stall) chk_beat("stall_hold", cur, prev_out);
    prev_stall = !apreset && toHdr_axis_tvalid && !toHdr_axis_tready;
    prev_out   = cur;
    if (!apreset && toHdr_axis_tvalid && toHdr_axis_tready) begin
      egress_beats++;
      if (sb_en) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_beat: got d=%h expected no beat", cur.d);
        end else begin
          chk_beat("egress_beat", cur, exp_q.pop_front());
        end
      end
    end
  end

  task automatic idle(input int n);
    fromMac_axis_tvalid = 1'b0;
    fromMac_axis_tlast  = 1'b0;
    repeat (n) begin @(posedge apclk); #1; end
  endtask

  task automatic drive_beat(input beat_t b);
    fromMac_axis_tdata  = b.d;
    fromMac_axis_tkeep  = b.k;
    fromMac_axis_tuser  = b.u;
    fromMac_axis_tlast  = b.l;
    fromMac_axis_tvalid = 1'b1;
  endtask

  task automatic send_pkt(input int pkt, input int len, input bit bad, input bit deliver);
    for (int i = 0; i < len; i++) begin
      beat_t b;
      b = mk_beat(pkt, i, len, bad);
      drive_beat(b);
      if (deliver) exp_q.push_back(b);
      @(posedge apclk); #1;
    end
    fromMac_axis_tvalid = 1'b0;
    fromMac_axis_tlast  = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin @(posedge apclk); n++; end
    chk({name, "_drain_left"}, 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge apclk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vecs[9];
    int   b0, tot;
    vecs[0] = '{3,  1'b1, 1'b0, 1};   // bad frame
    vecs[1] = '{2,  1'b0, 1'b1, 1};   // good after bad
    vecs[2] = '{1,  1'b0, 1'b1, 1};   // single beat
    vecs[3] = '{1,  1'b1, 1'b0, 2};   // single bad beat
    vecs[4] = '{16, 1'b0, 1'b1, 2};   // exactly DEPTH beats
    vecs[5] = '{20, 1'b0, 1'b0, 3};   // oversize via DROP state
    vecs[6] = '{1,  1'b0, 1'b1, 3};   // recovery
    vecs[7] = '{17, 1'b0, 1'b0, 4};   // full on the tlast beat
    vecs[8] = '{5,  1'b0, 1'b1, 4};

    apreset = 1'b1;
    fromMac_axis_tdata = '0; fromMac_axis_tkeep = '0; fromMac_axis_tuser = '0;
    fromMac_axis_tlast = 1'b0; fromMac_axis_tvalid = 1'b0;
    toHdr_axis_tready = 1'b1;
    repeat (3) begin @(posedge apclk); #1; end

    chk("rst_in_tready", 64'(fromMac_axis_tready), 64'd0);
    chk("rst_out_tvalid", 64'(toHdr_axis_tvalid), 64'd0);
    chk("rst_out_tdata", toHdr_axis_tdata, 64'd0);
    chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    apreset = 1'b0;
    #1;
    chk("run_in_tready", 64'(fromMac_axis_tready), 64'd1);
    @(posedge apclk); #1;
    sb_en = 1'b1;

    // 4-beat good packet: first egress beat two edges after the commit edge.
    b0 = egress_beats;
    send_pkt(1, 4, 1'b0, 1'b1);
    chk("commit_pkt_cnt", 64'(pkt_cnt), 64'd1);
    chk("lat_edge0_tvalid", 64'(toHdr_axis_tvalid), 64'd0);
    @(posedge apclk); #1;
    chk("lat_edge1_tvalid", 64'(toHdr_axis_tvalid), 64'd0);
    @(posedge apclk); #1;
    chk("lat_edge2_tvalid", 64'(toHdr_axis_tvalid), 64'd1);
    drain("p1");
    chk("p1_beats", 64'(egress_beats - b0), 64'd4);
    chk("p1_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("p1_drop_cnt", 64'(drop_cnt), 64'd0);

    for (int i = 0; i < 9; i++) begin
      b0 = egress_beats;
      send_pkt(10 + i, vecs[i].len, vecs[i].bad, vecs[i].deliver);
      idle(1);
      drain("vec");
      chk("vec_drop_cnt", 64'(drop_cnt), 64'(vecs[i].exp_drop));
      chk("vec_pkt_cnt", 64'(pkt_cnt), 64'd0);
      chk("vec_beats", 64'(egress_beats - b0), vecs[i].deliver ? 64'(vecs[i].len) : 64'd0);
    end

    // Fill with egress stalled, then overflow with a fourth packet.
    toHdr_axis_tready = 1'b0;
    b0 = egress_beats;
    for (int p = 0; p < 3; p++) send_pkt(30 + p, 5, 1'b0, 1'b1);
    idle(2);
    chk("full_pkt_cnt", 64'(pkt_cnt), 64'd3);
    send_pkt(33, 5, 1'b0, 1'b0);
    idle(2);
    chk("full_drop_cnt", 64'(drop_cnt), 64'd5);
    chk("full_pkt_cnt_after", 64'(pkt_cnt), 64'd3);
    chk("full_no_egress", 64'(egress_beats - b0), 64'd0);
    toHdr_axis_tready = 1'b1;
    drain("full");
    chk("full_beats", 64'(egress_beats - b0), 64'd15);
    chk("full_pkt_cnt_end", 64'(pkt_cnt), 64'd0);

    // Packet stream with egress 50 cycles on / 10 off.
    b0 = egress_beats;
    tot = 0;
    stream_done = 1'b0;
    fork
      begin
        for (int p = 0; p < 30; p++) begin
          send_pkt(100 + p, 1 + (p % 4), 1'b0, 1'b1);
          tot += 1 + (p % 4);
          idle(2);
        end
        stream_done = 1'b1;
      end
      begin
        for (int c = 0; !stream_done; c++) begin
          toHdr_axis_tready = ((c % 60) < 50);
          @(posedge apclk); #1;
        end
      end
    join
    toHdr_axis_tready = 1'b1;
    drain("stream");
    chk("stream_beats", 64'(egress_beats - b0), 64'(tot));
    chk("stream_drop_cnt", 64'(drop_cnt), 64'd5);
    chk("stream_pkt_cnt", 64'(pkt_cnt), 64'd0);

    // Reset while egress and ingress are both mid-packet.
    sb_en = 1'b0;
    toHdr_axis_tready = 1'b0;
    send_pkt(200, 4, 1'b0, 1'b0);
    idle(3);
    toHdr_axis_tready = 1'b1;
    @(posedge apclk); #1;
    toHdr_axis_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_beat(mk_beat(201, i, 5, 1'b0));
      @(posedge apclk); #1;
    end
    apreset = 1'b1;
    @(posedge apclk); #1;
    chk("midrst_in_tready", 64'(fromMac_axis_tready), 64'd0);
    chk("midrst_out_tvalid", 64'(toHdr_axis_tvalid), 64'd0);
    chk("midrst_out_tdata", toHdr_axis_tdata, 64'd0);
    chk("midrst_out_tkeep", 64'(toHdr_axis_tkeep), 64'd0);
    chk("midrst_out_tuser", toHdr_axis_tuser, 64'd0);
    chk("midrst_out_tlast", 64'(toHdr_axis_tlast), 64'd0);
    @(posedge apclk); #1;
    apreset = 1'b0;
    fromMac_axis_tvalid = 1'b0;
    fromMac_axis_tlast  = 1'b0;
    chk("midrst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("midrst_drop_cnt", 64'(drop_cnt), 64'd0);
    exp_q.delete();
    toHdr_axis_tready = 1'b1;
    @(posedge apclk); #1;
    sb_en = 1'b1;
    b0 = egress_beats;
    send_pkt(210, 3, 1'b0, 1'b1);
    drain("post_rst");
    chk("post_rst_beats", 64'(egress_beats - b0), 64'd3);
    chk("post_rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("post_rst_drop_cnt", 64'(drop_cnt), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
